instruction_fetch_unit: RTL
===========================

Name: instruction_fetch_unit

Overview:
- Initiator side of the instruction cache interface: owns the program counter, drives `PC` into the cache every clock and captures the returned `instruction`.
- Captured instructions are buffered and handed to decode over a valid/ready handshake.
- Supports taken-branch redirect with squash of in-flight and buffered fetches.
- Detects the cache miss sentinel word and halts fetch with a sticky fault.

Parameters:
RESET_PC, 32'h0000_0100, PC loaded on reset (block address 0x20)
PC_STRIDE, 8, bytes added to PC per sequential fetch (one instruction per 8-byte block)
BUF_DEPTH, 2, entries in output buffer (power of two, 2..8)
MISS_WORD, 32'hDEAD_BEEF, cache-returned word that signals a miss

Ports:
clock  in  1  main clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
PC  out  32  fetch address to cache (registered)
instruction  in  32  cache data; valid the cycle after the edge that sampled PC
branch_taken  in  1  redirect request, sampled on rising edge
branch_target  in  32  redirect address, used as-is (cache ignores bits [2:0])
out_valid  out  1  buffer head holds an instruction
out_ready  in  1  decode accepts head this edge when out_valid=1
out_instruction  out  32  head instruction
out_pc  out  32  address the head instruction was fetched from
fault  out  1  sticky miss indication
fault_pc  out  32  address that returned MISS_WORD

Behaviour:
- Reset (async, immediate):
  - PC=RESET_PC; out_valid=0; out_instruction=0; out_pc=0; fault=0; fault_pc=0.
  - Buffer empty; in-flight flag cleared.
- In-flight tracking:
  - Issuing at an edge sets inflight_valid=1 and inflight_pc=PC (the address the cache sampled), then advances PC by PC_STRIDE.
  - Not issuing clears inflight_valid; PC holds, so the cache re-reads the same address harmlessly.
- Issue condition: !fault && (count + inflight_valid − pop) < BUF_DEPTH, where pop = out_valid && out_ready.
  - Guarantees no capture is ever dropped for lack of space.
- Capture: at each edge with inflight_valid=1, push {inflight_pc, instruction} to the buffer tail.
  - Push and pop in the same edge are both allowed; count is unchanged.
- Throughput and latency:
  - Sustained 1 instruction/cycle with out_ready held high.
  - First out_valid rises after the 2nd rising edge following reset release (issue, then capture).
- Output:
  - out_valid = (count != 0).
  - out_instruction and out_pc come from the buffer head and are stable while out_valid && !out_ready.
- Miss: a capture whose instruction == MISS_WORD is not pushed. Instead:
  - fault<=1 and fault_pc<=inflight_pc.
  - Issue stops and inflight_valid is cleared.
  - Entries already buffered still drain normally.
  - fault clears only on reset; branch_taken is ignored while fault=1.
- Redirect (branch_taken=1 at an edge, fault=0):
  - PC<=branch_target; buffer flushed (count=0); inflight_valid<=0.
  - That edge's capture and pop are both discarded; out_valid=0 the following cycle.
  - Fetch resumes from the target at the next edge.
- Simultaneous events:
  - Redirect beats miss capture: no fault is raised and the sentinel is squashed.
  - Redirect beats push and pop.
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFF8 + 8 wraps to 32'h0000_0000 with no flag.
- Reset mid-operation: all state returns to reset values asynchronously; fetch restarts at RESET_PC after release.

Test Plan:
1. Release reset, out_ready=1 → PC = 0x100, 0x108, 0x110… per cycle; first out_valid after 2 edges with out_pc=0x100, out_instruction=32'h910006D6; then one instruction per cycle in order.
2. Hold out_ready=0 for 6 cycles after the first valid → count reaches BUF_DEPTH, PC freezes, head stays 0x100/32'h910006D6; on release the next outputs are 0x108 (32'h910020C6) then 0x110, with no duplicates or gaps.
3. With 2 entries buffered, pulse branch_taken with target 0x130 → next cycle out_valid=0 and PC=0x130; after 2 edges out_pc=0x130, out_instruction=32'hF8400043.
4. Redirect to 0x800 (block 0x100 maps to set 0 and mismatches, so the cache returns DEAD_BEEF) → fault=1, fault_pc=0x800, no output for 0x800, PC holds; a later branch_taken is ignored.
5. Assert branch_taken to 0x100 on the same edge the 0x800 sentinel is captured → fault stays 0 and output resumes at 0x100.
6. Set RESET_PC=32'hFFFF_FFF8 → second issued PC is 0x0. Separately, assert reset between edges mid-stream → out_valid, fault and out_pc drop immediately and PC=RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one fetch per cycle into the cache,
// buffers captured instructions for decode, handles branch redirect and miss fault.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0100,
    parameter int unsigned PC_STRIDE = 8,
    parameter int unsigned BUF_DEPTH = 2,
    parameter logic [31:0] MISS_WORD = 32'hDEAD_BEEF
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] PC,
    input  logic [31:0] instruction,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc,
    output logic        fault,
    output logic [31:0] fault_pc
);

    localparam int unsigned PW = $clog2(BUF_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [31:0]   bufInstr [BUF_DEPTH];
    logic [31:0]   bufPc    [BUF_DEPTH];
    logic [PW-1:0] headPtr;
    logic [PW-1:0] tailPtr;
    logic [CW-1:0] count;
    logic          inflightValid;
    logic [31:0]   inflightPc;

    logic          pop;
    logic          miss;
    logic          push;
    logic          issue;
    logic [CW:0]   occupancy;

    assign out_valid       = (count != '0);
    assign out_instruction = bufInstr[headPtr];
    assign out_pc          = bufPc[headPtr];

    // Occupancy counts the in-flight fetch as already buffered, so a capture always has room.
    always_comb begin
        pop       = out_valid && out_ready;
        miss      = inflightValid && (instruction == MISS_WORD);
        push      = inflightValid && !miss;
        occupancy = {1'b0, count} + (CW+1)'(inflightValid) - (CW+1)'(pop);
        issue     = !fault && (occupancy < (CW+1)'(BUF_DEPTH));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            PC            <= RESET_PC;
            inflightValid <= 1'b0;
            inflightPc    <= '0;
            headPtr       <= '0;
            tailPtr       <= '0;
            count         <= '0;
            fault         <= 1'b0;
            fault_pc      <= '0;
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                bufInstr[i] <= '0;
                bufPc[i]    <= '0;
            end
        end else if (branch_taken && !fault) begin
            // Redirect squashes this edge's capture and pop along with the whole buffer.
            PC            <= branch_target;
            inflightValid <= 1'b0;
            headPtr       <= '0;
            tailPtr       <= '0;
            count         <= '0;
        end else begin
            if (miss) begin
                fault         <= 1'b1;
                fault_pc      <= inflightPc;
                inflightValid <= 1'b0;
            end else if (issue) begin
                inflightValid <= 1'b1;
                inflightPc    <= PC;
                PC            <= PC + 32'(PC_STRIDE);
            end else begin
                inflightValid <= 1'b0;
            end

            if (push) begin
                bufInstr[tailPtr] <= instruction;
                bufPc[tailPtr]    <= inflightPc;
                tailPtr           <= tailPtr + PW'(1);
            end
            if (pop) begin
                headPtr <= headPtr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule
